dm_bus_ctrl: RTL and testbench
==============================

DM_BUS_CTRL -- requirements
Module: dm_bus_ctrl

Interface
REQ-001 Parameter XLEN, default 32, datapath width; only 32 is supported and elaboration SHALL fail for any other value.
REQ-002 Parameter TIMEOUT, default 16, maximum cycles spent in REQ+RSP before the access aborts; legal range 2..255.
REQ-003 i_clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_lsu_valid  input  1  core load/store request; held stable by the core while o_lsu_stall=1.
REQ-006 i_lsu_we  input  1  1=store, 0=load.
REQ-007 i_lsu_op  input  3  width code: MemB=000, MemH=001, MemW=010, MemBU=100, MemHU=101; other codes SHALL complete with error and no bus access.
REQ-008 i_lsu_addr  input  XLEN  byte address from the ALU result.
REQ-009 i_lsu_wdata  input  XLEN  store data, rs2 value, LSB-aligned.
REQ-010 o_lsu_stall  output  1  core SHALL hold the pipeline while high.
REQ-011 o_lsu_done  output  1  one-cycle completion pulse.
REQ-012 o_lsu_rdata  output  XLEN  extended load data, valid while o_lsu_done=1.
REQ-013 o_lsu_err  output  1  access faulted, valid while o_lsu_done=1.
REQ-014 o_bus_req, o_bus_we  output  1 each  bus request and direction.
REQ-015 o_bus_addr  output  XLEN  word-aligned address; bits [1:0] SHALL be 00.
REQ-016 o_bus_wdata  output  XLEN; o_bus_wstrb  output  XLEN/8  lane-placed store data and byte enables.
REQ-017 i_bus_gnt, i_bus_rvalid, i_bus_err  input  1 each; i_bus_rdata  input  XLEN  bus grant, response, error and read word.

Function
REQ-018 FSM states: IDLE, REQ, RSP, DONE; IDLE->REQ on i_lsu_valid, capturing we/op/addr/wdata into registers.
REQ-019 REQ: o_bus_req=1 from registered outputs; i_bus_gnt=1 -> RSP; o_bus_req SHALL drop in the cycle after grant.
REQ-020 RSP: i_bus_rvalid=1 -> DONE, capturing i_bus_rdata and i_bus_err; stores also wait for i_bus_rvalid as write acknowledge.
REQ-021 DONE lasts exactly one cycle with o_lsu_done=1, then IDLE; a new request is accepted no earlier than the following IDLE cycle.
REQ-022 o_lsu_stall = i_lsu_valid AND NOT o_lsu_done (combinational).
REQ-023 Minimum latency: valid at cycle 0, req at cycle 1 with gnt, rvalid at cycle 2, done at cycle 3.
REQ-024 A cycle counter SHALL clear on entry to REQ, increment in REQ and RSP, and at count TIMEOUT force DONE with o_lsu_err=1 and o_lsu_rdata=0.
REQ-025 i_bus_err=1 with i_bus_rvalid SHALL give o_lsu_err=1 and o_lsu_rdata=0.
REQ-026 wstrb for stores: B = 0001 shifted left by addr[1:0]; H = 0011 shifted left by 2*addr[1]; W = 1111; loads = 0000.
REQ-027 o_bus_wdata: B replicates byte [7:0] into all four lanes; H replicates [15:0] into both halves; W passes through.
REQ-028 Load data: i_bus_rdata shifted right by 8*addr[1:0], then sign-extended (MemB/MemH) or zero-extended (MemBU/MemHU) from bit 7/15; MemW passes through.
REQ-029 i_bus_rvalid or i_bus_gnt outside the state that expects it SHALL be ignored.
REQ-030 Simultaneous timeout expiry and i_bus_rvalid in RSP: the response wins and o_lsu_err reflects i_bus_err only.

Reset
REQ-031 Asserting i_rst_n=0 SHALL immediately force IDLE, counter 0, and all outputs to 0, including o_bus_req during mid-transaction.
REQ-032 After reset release, a pending i_lsu_valid SHALL start a new access; no partial access resumes.

Configuration
REQ-033 Macro DM_MISALIGN_TRAP_EN defined: H with addr[0]=1 or W with addr[1:0]!=00 SHALL go IDLE->DONE without a bus request and set o_lsu_err=1 with rdata 0.
REQ-034 Macro DM_MISALIGN_TRAP_EN undefined: misaligned low bits are ignored (H uses addr[1] only, W uses neither), and the access proceeds normally without error.

Verification
REQ-035 Load MemB at addr 0x103, bus rdata 0x80FF_FF01, gnt and rvalid immediate -> done at cycle 3, rdata 0xFFFF_FF80, err 0.
REQ-036 Store MemH at addr 0x202, wdata 0x1234_ABCD -> bus addr 0x200, wstrb 1100, wdata 0xABCD_ABCD, we 1.
REQ-037 Load MemHU at addr 0x0, gnt delayed 3 cycles, rvalid 2 cycles later, rdata 0x0000_8001 -> o_bus_req high for 3 cycles, done at cycle 7, rdata 0x0000_8001, stall high cycles 0-6.
REQ-038 TIMEOUT=4, gnt never asserted -> done with err=1 and rdata 0 at cycle 5; o_bus_req low afterward.
REQ-039 MemW at addr 0x6: with DM_MISALIGN_TRAP_EN -> no o_bus_req, done at cycle 2 with err=1; without it -> bus addr 0x4, normal completion.
REQ-040 Reset asserted in RSP -> o_bus_req, o_lsu_done and o_lsu_stall-related state clear at once; i_bus_rvalid arriving later produces no done pulse.

Source files
------------

// File: rtl/dm_bus_ctrl.sv
// dm_bus_ctrl: load/store unit to single-outstanding bus bridge.
// Captures a core access, places store data/strobes on byte lanes, runs a
// REQ/RSP handshake with a cycle-count timeout and returns extended load data.
// Optional feature: define DM_MISALIGN_TRAP_EN to fault misaligned H/W accesses
// without issuing a bus request; when undefined, misaligned low bits are ignored.
module dm_bus_ctrl #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lsu_valid,
  input  logic              i_lsu_we,
  input  logic [2:0]        i_lsu_op,
  input  logic [XLEN-1:0]   i_lsu_addr,
  input  logic [XLEN-1:0]   i_lsu_wdata,
  output logic              o_lsu_stall,
  output logic              o_lsu_done,
  output logic [XLEN-1:0]   o_lsu_rdata,
  output logic              o_lsu_err,
  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic [XLEN-1:0]   o_bus_addr,
  output logic [XLEN-1:0]   o_bus_wdata,
  output logic [XLEN/8-1:0] o_bus_wstrb,
  input  logic              i_bus_gnt,
  input  logic              i_bus_rvalid,
  input  logic              i_bus_err,
  input  logic [XLEN-1:0]   i_bus_rdata
);

  // Lane placement below assumes four byte lanes; refuse anything else.
  if (XLEN != 32) begin : g_bad_xlen
    $error("dm_bus_ctrl: XLEN must be 32");
  end
  // The counter is 8 bits wide and must allow at least one REQ and one RSP cycle.
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("dm_bus_ctrl: TIMEOUT must be in 2..255");
  end

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_DONE} state_t;

  state_t              state_reg, state_next;
  logic [7:0]          cnt_reg, cnt_next;
  logic [2:0]          op_reg;
  logic [1:0]          off_reg;
  logic                fault_reg;
  logic                bus_req_reg;
  logic                bus_we_reg;
  logic [XLEN-1:0]     bus_addr_reg;
  logic [XLEN-1:0]     bus_wdata_reg;
  logic [XLEN/8-1:0]   bus_wstrb_reg;
  logic [XLEN-1:0]     rdata_reg;
  logic                err_reg;
  logic                rsp_take;
  logic                abort;

  // ---- decode of the incoming request (used only at capture) ----
  logic                in_byte, in_half, in_word, in_misalign, in_fault;
  logic [XLEN/8-1:0]   wstrb_in;
  logic [XLEN-1:0]     wdata_in;

  assign in_byte = (i_lsu_op == OP_B) || (i_lsu_op == OP_BU);
  assign in_half = (i_lsu_op == OP_H) || (i_lsu_op == OP_HU);
  assign in_word = (i_lsu_op == OP_W);

`ifdef DM_MISALIGN_TRAP_EN
  assign in_misalign = (in_half && i_lsu_addr[0]) ||
                       (in_word && (i_lsu_addr[1:0] != 2'b00));
`else
  assign in_misalign = 1'b0;
`endif

  // Unknown width codes and trapped misalignment never reach the bus.
  assign in_fault = !(in_byte || in_half || in_word) || in_misalign;

  // Byte enables for stores; loads drive no strobes.
  always_comb begin
    wstrb_in = '0;
    if (i_lsu_we) begin
      if (in_byte)      wstrb_in = 4'b0001 << i_lsu_addr[1:0];
      else if (in_half) wstrb_in = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
      else if (in_word) wstrb_in = 4'b1111;
    end
  end

  // Replicate the narrow store operand into every lane it could land in.
  genvar gi;
  for (gi = 0; gi < XLEN/8; gi++) begin : g_lane
    assign wdata_in[8*gi +: 8] = in_byte ? i_lsu_wdata[7:0] :
                                 in_half ? i_lsu_wdata[8*(gi%2) +: 8] :
                                           i_lsu_wdata[8*gi +: 8];
  end

  // ---- load data alignment and extension from the captured op/offset ----
  logic [4:0]      shamt;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] load_ext;

  // Move the addressed byte/half down to bit 0, then extend by op.
  always_comb begin
    shamt = '0;
    if (op_reg == OP_B || op_reg == OP_BU)      shamt = {off_reg, 3'b000};
    else if (op_reg == OP_H || op_reg == OP_HU) shamt = {off_reg[1], 4'b0000};
    shifted  = i_bus_rdata >> shamt;
    load_ext = shifted;
    case (op_reg)
      OP_B:    load_ext = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      OP_BU:   load_ext = {{(XLEN-8){1'b0}}, shifted[7:0]};
      OP_H:    load_ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      OP_HU:   load_ext = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  // State and cycle-counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next state; a faulted access passes through REQ without requesting so its
  // completion lines up with the captured fault flag. In RSP the response
  // beats a coinciding timeout.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rsp_take   = 1'b0;
    abort      = 1'b0;
    unique case (state_reg)
      S_IDLE: begin
        cnt_next = '0;
        if (i_lsu_valid) state_next = S_REQ;
      end
      S_REQ: begin
        cnt_next = cnt_reg + 8'd1;
        if (fault_reg || cnt_reg == CNT_LAST) begin
          state_next = S_DONE;
          abort      = 1'b1;
        end else if (i_bus_gnt) begin
          state_next = S_RSP;
        end
      end
      S_RSP: begin
        cnt_next = cnt_reg + 8'd1;
        if (i_bus_rvalid) begin
          state_next = S_DONE;
          rsp_take   = 1'b1;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = S_DONE;
          abort      = 1'b1;
        end
      end
      S_DONE: begin
        cnt_next   = '0;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Bus request is registered: high for every cycle spent in REQ, never for faults.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) bus_req_reg <= 1'b0;
    else          bus_req_reg <= (state_next == S_REQ) &&
                                 !(state_reg == S_IDLE && in_fault);
  end

  // Capture the access on acceptance and the result on completion.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_reg        <= '0;
      off_reg       <= '0;
      fault_reg     <= 1'b0;
      bus_we_reg    <= 1'b0;
      bus_addr_reg  <= '0;
      bus_wdata_reg <= '0;
      bus_wstrb_reg <= '0;
      rdata_reg     <= '0;
      err_reg       <= 1'b0;
    end else if (state_reg == S_IDLE && i_lsu_valid) begin
      op_reg        <= i_lsu_op;
      off_reg       <= i_lsu_addr[1:0];
      fault_reg     <= in_fault;
      bus_we_reg    <= i_lsu_we;
      bus_addr_reg  <= {i_lsu_addr[XLEN-1:2], 2'b00};
      bus_wdata_reg <= wdata_in;
      bus_wstrb_reg <= wstrb_in;
      rdata_reg     <= '0;
      err_reg       <= 1'b0;
    end else if (abort) begin
      rdata_reg <= '0;
      err_reg   <= 1'b1;
    end else if (rsp_take) begin
      rdata_reg <= (i_bus_err || bus_we_reg) ? '0 : load_ext;
      err_reg   <= i_bus_err;
    end
  end

  assign o_lsu_done  = (state_reg == S_DONE);
  assign o_lsu_stall = i_lsu_valid && !o_lsu_done;
  assign o_lsu_rdata = o_lsu_done ? rdata_reg : '0;
  assign o_lsu_err   = o_lsu_done && err_reg;
  assign o_bus_req   = bus_req_reg;
  assign o_bus_we    = bus_we_reg;
  assign o_bus_addr  = bus_addr_reg;
  assign o_bus_wdata = bus_wdata_reg;
  assign o_bus_wstrb = bus_wstrb_reg;

endmodule

// File: tb/tb_dm_bus_ctrl.sv
// Testbench for dm_bus_ctrl: table of directed accesses plus hand sequences
// for timeout, response/timeout collision and mid-transaction reset.
module tb_dm_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lsu_valid = 1'b0, lsu_we = 1'b0;
  logic [2:0]  lsu_op = '0;
  logic [31:0] lsu_addr = '0, lsu_wdata = '0;
  logic        bus_gnt = 1'b0, bus_rvalid = 1'b0, bus_err = 1'b0;
  logic [31:0] bus_rdata = '0;

  logic        stall_a, done_a, err_a, req_a, we_a;
  logic [31:0] rdata_a, addr_a, wdata_a;
  logic [3:0]  wstrb_a;
  logic        stall_b, done_b, err_b, req_b, we_b;
  logic [31:0] rdata_b, addr_b, wdata_b;
  logic [3:0]  wstrb_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dm_bus_ctrl #(.XLEN(32), .TIMEOUT(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_lsu_valid(lsu_valid), .i_lsu_we(lsu_we),
    .i_lsu_op(lsu_op), .i_lsu_addr(lsu_addr), .i_lsu_wdata(lsu_wdata),
    .o_lsu_stall(stall_a), .o_lsu_done(done_a), .o_lsu_rdata(rdata_a), .o_lsu_err(err_a),
    .o_bus_req(req_a), .o_bus_we(we_a), .o_bus_addr(addr_a), .o_bus_wdata(wdata_a),
    .o_bus_wstrb(wstrb_a), .i_bus_gnt(bus_gnt), .i_bus_rvalid(bus_rvalid),
    .i_bus_err(bus_err), .i_bus_rdata(bus_rdata)
  );

  dm_bus_ctrl #(.XLEN(32), .TIMEOUT(4)) dut_to (
    .i_clk(clk), .i_rst_n(rst_n), .i_lsu_valid(lsu_valid), .i_lsu_we(lsu_we),
    .i_lsu_op(lsu_op), .i_lsu_addr(lsu_addr), .i_lsu_wdata(lsu_wdata),
    .o_lsu_stall(stall_b), .o_lsu_done(done_b), .o_lsu_rdata(rdata_b), .o_lsu_err(err_b),
    .o_bus_req(req_b), .o_bus_we(we_b), .o_bus_addr(addr_b), .o_bus_wdata(wdata_b),
    .o_bus_wstrb(wstrb_b), .i_bus_gnt(bus_gnt), .i_bus_rvalid(bus_rvalid),
    .i_bus_err(bus_err), .i_bus_rdata(bus_rdata)
  );

  typedef struct {
    logic [2:0]  op;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] bus_rdata;
    logic        bus_err;
    int          gnt_cyc;
    int          rv_cyc;
    int          stray_cyc;
    logic [31:0] exp_addr;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_done;
    int          exp_req;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  function automatic vec_t mk(logic [2:0] op, logic we, logic [31:0] addr, logic [31:0] wdata,
                              logic [31:0] brd, logic berr, int gc, int rc, int sc,
                              logic [31:0] ea, logic [3:0] es, logic [31:0] ew,
                              logic [31:0] er, logic ee, int ed, int eq);
    vec_t v;
    v.op = op; v.we = we; v.addr = addr; v.wdata = wdata; v.bus_rdata = brd; v.bus_err = berr;
    v.gnt_cyc = gc; v.rv_cyc = rc; v.stray_cyc = sc;
    v.exp_addr = ea; v.exp_wstrb = es; v.exp_wdata = ew; v.exp_rdata = er; v.exp_err = ee;
    v.exp_done = ed; v.exp_req = eq;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    lsu_valid = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int done_cyc, req_cnt, stall_cnt;
    logic got_req;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic [3:0]  c_wstrb;
    logic        c_we, c_err;
    v = vecs[idx];
    lsu_valid = 1'b1; lsu_we = v.we; lsu_op = v.op; lsu_addr = v.addr; lsu_wdata = v.wdata;
    bus_rdata = v.bus_rdata; bus_err = v.bus_err;
    done_cyc = -1; req_cnt = 0; stall_cnt = 0; got_req = 1'b0;
    c_addr = '0; c_wdata = '0; c_rdata = '0; c_wstrb = '0; c_we = 1'b0; c_err = 1'b0;
    for (int c = 0; c < 40 && done_cyc < 0; c++) begin
      bus_gnt    = (c == v.gnt_cyc);
      bus_rvalid = (c == v.rv_cyc) || (c == v.stray_cyc);
      @(negedge clk);
      if (req_a) begin
        req_cnt++;
        if (!got_req) begin
          got_req = 1'b1;
          c_addr = addr_a; c_wdata = wdata_a; c_wstrb = wstrb_a; c_we = we_a;
        end
      end
      if (stall_a) stall_cnt++;
      if (done_a) begin
        done_cyc = c; c_rdata = rdata_a; c_err = err_a;
      end
      step();
    end
    lsu_valid = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d done_one_cycle", idx), {31'b0, done_a}, 32'd0);
    step();
    chk($sformatf("v%0d done_cycle", idx), done_cyc, v.exp_done);
    chk($sformatf("v%0d rdata", idx), c_rdata, v.exp_rdata);
    chk($sformatf("v%0d err", idx), {31'b0, c_err}, {31'b0, v.exp_err});
    chk($sformatf("v%0d req_cycles", idx), req_cnt, v.exp_req);
    chk($sformatf("v%0d stall_cycles", idx), stall_cnt, v.exp_done);
    if (v.exp_req > 0) begin
      chk($sformatf("v%0d bus_addr", idx), c_addr, v.exp_addr);
      chk($sformatf("v%0d bus_wstrb", idx), {28'b0, c_wstrb}, {28'b0, v.exp_wstrb});
      chk($sformatf("v%0d bus_wdata", idx), c_wdata, v.exp_wdata);
      chk($sformatf("v%0d bus_we", idx), {31'b0, c_we}, {31'b0, v.we});
    end
    $display("txn %0d: op=%0d we=%0d addr=0x%08h done_cycle=%0d rdata=0x%08h err=%0d req_cycles=%0d",
             idx, v.op, v.we, v.addr, done_cyc, c_rdata, c_err, req_cnt);
  endtask

  initial begin
    int          done_cyc, done_cnt;
    logic [31:0] cap_rdata;
    logic        cap_err;
    logic        req_hist [0:7];

    // op, we, addr, wdata, bus_rdata, bus_err, gnt, rvalid, stray,
    // exp bus addr, wstrb, bus wdata, rdata, err, done cycle, req cycles
    vecs[0]  = mk(3'b000, 0, 32'h103, 32'h0, 32'h80FF_FF01, 0, 1, 2, 99,
                  32'h100, 4'b0000, 32'h0, 32'hFFFF_FF80, 0, 3, 1);
    vecs[1]  = mk(3'b001, 1, 32'h202, 32'h1234_ABCD, 32'h0, 0, 1, 2, 99,
                  32'h200, 4'b1100, 32'hABCD_ABCD, 32'h0, 0, 3, 1);
    vecs[2]  = mk(3'b101, 0, 32'h0, 32'h0, 32'h0000_8001, 0, 3, 6, 2,
                  32'h0, 4'b0000, 32'h0, 32'h0000_8001, 0, 7, 3);
`ifdef DM_MISALIGN_TRAP_EN
    vecs[3]  = mk(3'b010, 0, 32'h6, 32'h0, 32'hDEAD_BEEF, 0, 1, 2, 99,
                  32'h4, 4'b0000, 32'h0, 32'h0, 1, 2, 0);
`else
    vecs[3]  = mk(3'b010, 0, 32'h6, 32'h0, 32'hDEAD_BEEF, 0, 1, 2, 99,
                  32'h4, 4'b0000, 32'h0, 32'hDEAD_BEEF, 0, 3, 1);
`endif
    vecs[4]  = mk(3'b001, 0, 32'h2, 32'h0, 32'h8001_7FFF, 0, 1, 2, 99,
                  32'h0, 4'b0000, 32'h0, 32'hFFFF_8001, 0, 3, 1);
    vecs[5]  = mk(3'b100, 0, 32'h1, 32'h0, 32'h0000_F000, 0, 1, 2, 99,
                  32'h0, 4'b0000, 32'h0, 32'h0000_00F0, 0, 3, 1);
    vecs[6]  = mk(3'b000, 1, 32'h1, 32'h0000_00A5, 32'h0, 0, 1, 2, 99,
                  32'h0, 4'b0010, 32'hA5A5_A5A5, 32'h0, 0, 3, 1);
    vecs[7]  = mk(3'b010, 1, 32'h10, 32'hCAFE_F00D, 32'h0, 0, 2, 4, 99,
                  32'h10, 4'b1111, 32'hCAFE_F00D, 32'h0, 0, 5, 2);
    vecs[8]  = mk(3'b010, 0, 32'h20, 32'h0, 32'h1111_1111, 1, 1, 2, 99,
                  32'h20, 4'b0000, 32'h0, 32'h0, 1, 3, 1);
    vecs[9]  = mk(3'b011, 0, 32'h30, 32'h0, 32'h5555_5555, 0, 1, 2, 99,
                  32'h30, 4'b0000, 32'h0, 32'h0, 1, 2, 0);
    vecs[10] = mk(3'b000, 0, 32'h0, 32'h0, 32'h0000_007F, 0, 1, 2, 99,
                  32'h0, 4'b0000, 32'h0, 32'h0000_007F, 0, 3, 1);
`ifdef DM_MISALIGN_TRAP_EN
    vecs[11] = mk(3'b001, 0, 32'h3, 32'h0, 32'h7FFF_0000, 0, 1, 2, 99,
                  32'h0, 4'b0000, 32'h0, 32'h0, 1, 2, 0);
`else
    vecs[11] = mk(3'b001, 0, 32'h3, 32'h0, 32'h7FFF_0000, 0, 1, 2, 99,
                  32'h0, 4'b0000, 32'h0, 32'h0000_7FFF, 0, 3, 1);
`endif

    // Reset state, observed while reset is held.
    step();
    step();
    chk("rst bus_req", {31'b0, req_a}, 32'd0);
    chk("rst done", {31'b0, done_a}, 32'd0);
    chk("rst err", {31'b0, err_a}, 32'd0);
    chk("rst rdata", rdata_a, 32'd0);
    chk("rst bus_addr", addr_a, 32'd0);
    chk("rst bus_wstrb", {28'b0, wstrb_a}, 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < NVEC; i++) run_vec(i);

    // Timeout: TIMEOUT=4 instance, grant never arrives.
    apply_reset();
    lsu_valid = 1'b1; lsu_we = 1'b0; lsu_op = 3'b010; lsu_addr = 32'h40; bus_rdata = 32'hFFFF_FFFF;
    done_cyc = -1; cap_rdata = '0; cap_err = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      req_hist[c] = req_b;
      if (done_b && done_cyc < 0) begin
        done_cyc = c; cap_rdata = rdata_b; cap_err = err_b;
      end
      step();
      if (done_cyc >= 0) lsu_valid = 1'b0;
    end
    chk("timeout done_cycle", done_cyc, 5);
    chk("timeout err", {31'b0, cap_err}, 32'd1);
    chk("timeout rdata", cap_rdata, 32'd0);
    chk("timeout req_last_cycle", {31'b0, req_hist[4]}, 32'd1);
    chk("timeout req_after", {31'b0, req_hist[5]}, 32'd0);
    chk("timeout req_later", {31'b0, req_hist[7]}, 32'd0);
    $display("txn timeout: done_cycle=%0d err=%0d rdata=0x%08h", done_cyc, cap_err, cap_rdata);

    // Response arrives in the very cycle the timeout would expire.
    apply_reset();
    lsu_valid = 1'b1; lsu_we = 1'b0; lsu_op = 3'b010; lsu_addr = 32'h44;
    bus_rdata = 32'h1234_5678; bus_err = 1'b0;
    done_cyc = -1; cap_rdata = '0; cap_err = 1'b1;
    for (int c = 0; c < 8; c++) begin
      bus_gnt = (c == 1); bus_rvalid = (c == 4);
      @(negedge clk);
      if (done_b && done_cyc < 0) begin
        done_cyc = c; cap_rdata = rdata_b; cap_err = err_b;
      end
      step();
      if (done_cyc >= 0) lsu_valid = 1'b0;
    end
    chk("collide done_cycle", done_cyc, 5);
    chk("collide err", {31'b0, cap_err}, 32'd0);
    chk("collide rdata", cap_rdata, 32'h1234_5678);
    $display("txn collide: done_cycle=%0d err=%0d rdata=0x%08h", done_cyc, cap_err, cap_rdata);

    // Reset while waiting for the response; a late rvalid must not complete anything.
    apply_reset();
    lsu_valid = 1'b1; lsu_we = 1'b0; lsu_op = 3'b010; lsu_addr = 32'h50;
    step();
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    chk("rsp req_dropped", {31'b0, req_a}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rsp_rst req", {31'b0, req_a}, 32'd0);
    chk("rsp_rst done", {31'b0, done_a}, 32'd0);
    lsu_valid = 1'b0;
    step();
    rst_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      bus_rvalid = (c < 3);
      @(negedge clk);
      if (done_a) done_cnt++;
      step();
    end
    bus_rvalid = 1'b0;
    chk("rsp_rst late_rvalid_done", done_cnt, 0);
    $display("txn reset_in_rsp: done_pulses=%0d", done_cnt);

    // Reset while requesting drops o_bus_req at once; held valid restarts afterward.
    lsu_valid = 1'b1; lsu_we = 1'b0; lsu_op = 3'b000; lsu_addr = 32'h61;
    bus_rdata = 32'h0000_AB00; bus_err = 1'b0;
    step();
    @(negedge clk);
    chk("req_rst req_before", {31'b0, req_a}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("req_rst req_async", {31'b0, req_a}, 32'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("req_rst idle_after", {31'b0, req_a}, 32'd0);
    step();
    bus_gnt = 1'b1;
    @(negedge clk);
    chk("req_rst restart_req", {31'b0, req_a}, 32'd1);
    chk("req_rst restart_addr", addr_a, 32'h60);
    step();
    bus_gnt = 1'b0; bus_rvalid = 1'b1;
    step();
    bus_rvalid = 1'b0;
    @(negedge clk);
    chk("req_rst restart_done", {31'b0, done_a}, 32'd1);
    chk("req_rst restart_rdata", rdata_a, 32'hFFFF_FFAB);
    $display("txn reset_in_req: restart done=%0d rdata=0x%08h", done_a, rdata_a);
    step();
    lsu_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
